ks_addsub_pipe_16bit: RTL and testbench

Pipelined 16-bit Kogge-Stone adder/subtractor with valid/ready handshakes on input and output. It serves as the inverse-direction companion to the combinational KS adder: op selects A+B+Cin or A-B (A+~B+Cin). It sits between an operand source and a result consumer and returns sum, carry-out, signed-overflow and zero flags. It holds up to 3 operations in flight under backpressure.

---
 rtl/ks_pkg.sv | 21 ++
 rtl/ks_prefix_level.sv | 19 +
 rtl/ks_addsub_pipe_16bit.sv | 106 ++++++++++
 tb/tb_ks_addsub_pipe_16bit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared constants and stage-register types for the pipelined Kogge-Stone adder/subtractor.
package ks_pkg;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned KS_LEVELS = 4;
    localparam logic        OP_ADD    = 1'b0;
    localparam logic        OP_SUB    = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    typedef struct packed {
        logic             valid;
        gp_t              gp;
        logic [WIDTH-1:0] p0;
        logic             cin;
    } stage_t;

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level: combines each bit's (G,P) with the group SPAN positions below.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int unsigned SPAN = 1
) (
    input  gp_t gp_i,
    output gp_t gp_o
);

    always_comb begin
        gp_o = gp_i;
        for (int unsigned i = SPAN; i < WIDTH; i++) begin
            gp_o.g[i] = gp_i.g[i] | (gp_i.p[i] & gp_i.g[i-SPAN]);
            gp_o.p[i] = gp_i.p[i] & gp_i.p[i-SPAN];
        end
    end

endmodule

// File: rtl/ks_addsub_pipe_16bit.sv
// Three-stage pipelined 16-bit Kogge-Stone adder/subtractor with valid/ready handshakes
// and sum, carry-out, signed-overflow and zero flags.
module ks_addsub_pipe_16bit
    import ks_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    stage_t           r1_d, r1_q, r2_d, r2_q;
    gp_t              gp_s2_in, gp_l1, gp_l2, gp_l3, gp_l4;
    logic             en;
    logic             v3_q;
    logic [WIDTH-1:0] be, carry;
    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             z_d, z_q;
    logic             unused_p4;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign en       = !v3_q || out_ready;
    assign in_ready = en;

    always_comb begin
        be         = (op == OP_SUB) ? ~B : B;
        r1_d       = '0;
        r1_d.valid = in_valid;
        r1_d.gp.g  = A & be;
        r1_d.gp.p  = A ^ be;
        r1_d.p0    = A ^ be;
        r1_d.cin   = Cin;
    end

    // Folding Cin into bit 0 makes every final G[i] the carry into bit i+1.
    always_comb begin
        gp_s2_in      = r1_q.gp;
        gp_s2_in.g[0] = r1_q.gp.g[0] | (r1_q.gp.p[0] & r1_q.cin);
    end

    ks_prefix_level #(.SPAN(1)) u_lvl1 (.gp_i(gp_s2_in), .gp_o(gp_l1));
    ks_prefix_level #(.SPAN(2)) u_lvl2 (.gp_i(gp_l1),    .gp_o(gp_l2));

    always_comb begin
        r2_d       = '0;
        r2_d.valid = r1_q.valid;
        r2_d.gp    = gp_l2;
        r2_d.p0    = r1_q.p0;
        r2_d.cin   = r1_q.cin;
    end

    ks_prefix_level #(.SPAN(4)) u_lvl3 (.gp_i(r2_q.gp), .gp_o(gp_l3));
    ks_prefix_level #(.SPAN(8)) u_lvl4 (.gp_i(gp_l3),   .gp_o(gp_l4));

    // Overflow as carry-into-MSB xor carry-out, equivalent to the sign comparison form.
    always_comb begin
        carry  = {gp_l4.g[WIDTH-2:0], r2_q.cin};
        s_d    = r2_q.p0 ^ carry;
        cout_d = gp_l4.g[WIDTH-1];
        ovf_d  = gp_l4.g[WIDTH-1] ^ gp_l4.g[WIDTH-2];
        z_d    = (s_d == '0);
    end

    assign unused_p4 = ^gp_l4.p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q   <= '0;
            r2_q   <= '0;
            v3_q   <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            z_q    <= 1'b0;
        end else if (en) begin
            r1_q <= r1_d;
            r2_q <= r2_d;
            v3_q <= r2_q.valid;
            if (r2_q.valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                z_q    <= z_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = ovf_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_ks_addsub_pipe_16bit.sv
// Directed and randomized-handshake bench for ks_addsub_pipe_16bit with an ordered result scoreboard.
module tb_ks_addsub_pipe_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A, B;
    logic        Cin, op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout, V, Z;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_in     = 0;
    int unsigned n_out    = 0;
    logic [18:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[9];

    ks_addsub_pipe_16bit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .Cout     (Cout),
        .V        (V),
        .Z        (Z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed as {Z, V, Cout, S}.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] sum;
        logic        ovf;
        be  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, be} + {16'h0000, cin};
        ovf = (a[15] == be[15]) && (sum[15] != a[15]);
        return {(sum[15:0] == 16'h0000), ovf, sum[16], sum[15:0]};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [18:0] exp);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Cin      = cin;
        op       = sub;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(exp);
            n_in++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Inputs change only just after rising edges, so the negedge view matches the next edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                check($sformatf("result%0d", n_out), {13'd0, Z, V, Cout, S}, {13'd0, exp_q.pop_front()});
            end
            n_out++;
        end
    end

    initial begin
        logic [18:0] stall_exp0;
        logic [18:0] held;
        int unsigned target;
        int unsigned cyc;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 19'h068AC};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 19'h50000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 19'h1FFFF};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 19'h0FFFE};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 19'h37FFF};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 19'h28000};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 19'h50000};
        vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 19'h0FFFF};
        vecs[8] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 19'h50000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        op        = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flags", {13'd0, Z, V, Cout, S}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency from an empty pipe.
        send(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].op, vecs[0].exp);
        check("lat_edge0", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge2", {31'd0, out_valid}, 32'd1);

        for (int i = 1; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, vecs[i].exp);
        end
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: six back-to-back ops against a stalled consumer.
        out_ready  = 1'b0;
        stall_exp0 = model(16'h1001, 16'h0F0F, 1'b0, 1'b0);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(16'h1001 * 16'(k + 1), 16'h0F0F ^ 16'(k), 1'(k), 1'(k >> 1),
                         model(16'h1001 * 16'(k + 1), 16'h0F0F ^ 16'(k), 1'(k), 1'(k >> 1)));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                check("stall_head", {13'd0, Z, V, Cout, S}, {13'd0, stall_exp0});
                held = {Z, V, Cout, S};
                @(posedge clk);
                #2;
                check("stall_stable", {13'd0, Z, V, Cout, S}, {13'd0, held});
                out_ready = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    check($sformatf("no_gap%0d", k), {31'd0, out_valid}, 32'd1);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("stall_drained", exp_q.size(), 32'd0);

        // Random handshake traffic.
        target = n_out + 3000;
        fork
            begin
                for (int k = 0; k < 3000; k++) begin
                    logic [15:0] ra, rb;
                    logic        rc, ro;
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        A        = 16'($urandom);
                        @(posedge clk);
                        #1;
                    end
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    ro = 1'($urandom_range(0, 1));
                    send(ra, rb, rc, ro, model(ra, rb, rc, ro));
                end
            end
            begin
                cyc = 0;
                while (n_out < target && cyc < 40000) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                    cyc++;
                end
                if (n_out < target) check("random_timeout", n_out, target);
                out_ready = 1'b1;
            end
        join
        check("random_count", n_out, n_in);

        // Asynchronous reset with a full pipe: in-flight ops are dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(16'h0101 * 16'(i + 1), 16'h0003, 1'b0, 1'b0, model(16'h0101 * 16'(i + 1), 16'h0003, 1'b0, 1'b0));
        end
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_flags", {13'd0, Z, V, Cout, S}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        n_in = n_in - exp_q.size();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(vecs[8].a, vecs[8].b, vecs[8].cin, vecs[8].op, vecs[8].exp);
        repeat (5) @(posedge clk);
        #1;
        check("final_drained", exp_q.size(), 32'd0);
        check("final_count", n_out, n_in);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
